fwd_ctrl: RTL

Forwarding and load-use hazard controller for the five-stage pipeline. It is the producing end of the operand-forwarding path: it generates the 2-bit FwdA/FwdB selects consumed by the EXE-stage operand muxes, and the Stall/Flush controls for IF/ID. It tracks the destination of every in-flight instruction in an internal shadow pipeline (EXE, MEM, WB). It decides forwarding while the consumer is in ID and registers the decision so it is valid when the consumer enters EXE.

---
 rtl/fwd_pkg.sv | 17 +
 rtl/fwd_stage_reg.sv | 15 +
 rtl/fwd_ctrl.sv | 61 ++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// fwd_pkg: forwarding select codes and the shadow-pipeline entry type
package fwd_pkg;
  localparam logic [1:0] FWD_MEM = 2'b00;
  localparam logic [1:0] FWD_WB = 2'b01;
  localparam logic [1:0] FWD_RF = 2'b10;
  // Wide enough for any REG_AW the controller is built with; addresses are zero-extended.
  localparam int MAX_AW = 8;
  typedef struct packed {
    logic valid;
    logic [MAX_AW-1:0] rw;
    logic regwr;
    logic memtoreg;
  } shadow_t;
  function automatic logic is_writer(shadow_t e);
    return e.valid && e.regwr && e.rw != '0;
  endfunction
endpackage

// File: rtl/fwd_stage_reg.sv
// fwd_stage_reg: one shadow-pipeline stage with async clear, hold and bubble insert
module fwd_stage_reg import fwd_pkg::*; (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    hold,
  input  logic    bubble,
  input  shadow_t ent_i,
  output shadow_t ent_q
);
  shadow_t ent_d;
  always_comb ent_d = hold ? ent_q : (bubble ? '0 : ent_i);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ent_q <= '0;
    else ent_q <= ent_d;
endmodule

// File: rtl/fwd_ctrl.sv
// fwd_ctrl: operand-forwarding select and load-use stall controller
module fwd_ctrl import fwd_pkg::*; #(
  parameter int REG_AW = 5,
  parameter int CNT_W = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Hold,
  input  logic              ID_Valid,
  input  logic [REG_AW-1:0] ID_Rs,
  input  logic [REG_AW-1:0] ID_Rt,
  input  logic              ID_UseRs,
  input  logic              ID_UseRt,
  input  logic [REG_AW-1:0] ID_Rw,
  input  logic              ID_RegWr,
  input  logic              ID_MemtoReg,
  output logic [1:0]        FwdA,
  output logic [1:0]        FwdB,
  output logic              Stall,
  output logic              Flush,
  output logic [CNT_W-1:0]  StallCnt
);
  shadow_t id_ent, exe_q, mem_q, wb_q;
  logic [1:0] fwd_a_d, fwd_a_q, fwd_b_d, fwd_b_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [MAX_AW-1:0] rs, rt;
  // Nearest producer wins; a writer never has rw == 0, so $0 falls through to the register file.
  function automatic logic [1:0] next_sel(logic use_x, logic [MAX_AW-1:0] src);
    return !use_x ? FWD_RF :
           (is_writer(exe_q) && exe_q.rw == src) ? FWD_MEM :
           (is_writer(mem_q) && mem_q.rw == src) ? FWD_WB : FWD_RF;
  endfunction
  always_comb begin
    rs = MAX_AW'(ID_Rs);
    rt = MAX_AW'(ID_Rt);
    id_ent = '{valid: ID_Valid, rw: MAX_AW'(ID_Rw), regwr: ID_RegWr, memtoreg: ID_MemtoReg};
    Stall = ID_Valid && is_writer(exe_q) && exe_q.memtoreg &&
            ((ID_UseRs && exe_q.rw == rs) || (ID_UseRt && exe_q.rw == rt));
    Flush = Stall;
    fwd_a_d = Hold ? fwd_a_q : (Stall ? FWD_RF : next_sel(ID_UseRs, rs));
    fwd_b_d = Hold ? fwd_b_q : (Stall ? FWD_RF : next_sel(ID_UseRt, rt));
    cnt_d = (Stall && !Hold && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
      cnt_q <= '0;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q <= cnt_d;
    end
  fwd_stage_reg u_exe (.clk(Clk), .rst_n(Rst_n), .hold(Hold), .bubble(Stall || !ID_Valid), .ent_i(id_ent), .ent_q(exe_q));
  fwd_stage_reg u_mem (.clk(Clk), .rst_n(Rst_n), .hold(Hold), .bubble(1'b0), .ent_i(exe_q), .ent_q(mem_q));
  // WB stage is observability only and never participates in matching.
  fwd_stage_reg u_wb (.clk(Clk), .rst_n(Rst_n), .hold(Hold), .bubble(1'b0), .ent_i(mem_q), .ent_q(wb_q));
  assign FwdA = fwd_a_q;
  assign FwdB = fwd_b_q;
  assign StallCnt = cnt_q;
endmodule
